// File: rtl/cmm_errman_pkg.sv
// Shared types and constants for the correctable-error message manager.
// Holds the request FSM encoding, the default counter width and the delta direction encoding.
package cmm_errman_pkg;

  // Default width of the outstanding-correctable-error counter.
  localparam int unsigned CntWDefault = 4;

  // Width of the delta bus from the tally block (range 0..6).
  localparam int unsigned CorNumW = 3;

  // Direction encoding carried on inc_dec_b.
  localparam logic Inc = 1'b1;
  localparam logic Dec = 1'b0;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StReq    = 2'b01,
    StSettle = 2'b10
  } cor_state_e;

endpackage

// File: rtl/cmm_errman_cor_cnt_if.sv
// Tally-block / message-transmitter side bundle for the correctable-error counter.
// master = environment (tally block, transmitter, device control); slave = the counter block.
interface cmm_errman_cor_cnt_if #(
  parameter int unsigned CNT_W = cmm_errman_pkg::CntWDefault
);

  logic [cmm_errman_pkg::CorNumW-1:0] cor_num;
  logic                               inc_dec_b;
  logic                               reg_decr_cor;
  logic                               cor_en;
  logic                               msg_ack;
  logic                               ovfl_clr;
  logic                               cor_msg_req;
  logic                               decr_cor;
  logic [CNT_W-1:0]                   cor_cnt;
  logic                               cor_ovfl;

  modport master (
    output cor_num,
    output inc_dec_b,
    output reg_decr_cor,
    output cor_en,
    output msg_ack,
    output ovfl_clr,
    input  cor_msg_req,
    input  decr_cor,
    input  cor_cnt,
    input  cor_ovfl
  );

  modport slave (
    input  cor_num,
    input  inc_dec_b,
    input  reg_decr_cor,
    input  cor_en,
    input  msg_ack,
    input  ovfl_clr,
    output cor_msg_req,
    output decr_cor,
    output cor_cnt,
    output cor_ovfl
  );

endinterface

// File: rtl/cmm_errman_sat_add.sv
// Saturating add/subtract of a small delta onto a CNT_W-bit count.
// Clamps to 0..2^CNT_W-1 and flags when an add was clamped at the top.
module cmm_errman_sat_add #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned DW    = 3
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [DW-1:0]    delta_i,
  input  logic             add_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             clamp_hi_o
);

  // One guard bit above the wider operand so neither direction can wrap.
  localparam int unsigned ExtW = ((CNT_W > DW) ? CNT_W : DW) + 1;

  logic [ExtW-1:0] cnt_ext;
  logic [ExtW-1:0] delta_ext;
  logic [ExtW-1:0] max_ext;
  logic [ExtW-1:0] sum_ext;
  logic [ExtW-1:0] diff_ext;

  assign cnt_ext   = ExtW'(cnt_i);
  assign delta_ext = ExtW'(delta_i);
  assign max_ext   = ExtW'({CNT_W{1'b1}});
  assign sum_ext   = cnt_ext + delta_ext;
  assign diff_ext  = cnt_ext - delta_ext;

  always_comb begin
    cnt_o      = cnt_i;
    clamp_hi_o = 1'b0;
    if (add_i) begin
      if (sum_ext > max_ext) begin
        cnt_o      = {CNT_W{1'b1}};
        clamp_hi_o = 1'b1;
      end else begin
        cnt_o = sum_ext[CNT_W-1:0];
      end
    end else begin
      if (delta_ext > cnt_ext) begin
        cnt_o = '0;
      end else begin
        cnt_o = diff_ext[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cmm_errman_cor_cnt.sv
// Outstanding correctable-error counter and ERR_COR message request FSM.
// Optional sticky saturation flag built only when CMM_ERRMAN_COR_OVFL_EN is defined.
module cmm_errman_cor_cnt
  import cmm_errman_pkg::*;
#(
  parameter int unsigned CNT_W      = CntWDefault,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cmm_errman_cor_cnt_if.slave  bus
);

  // A zero settle length would let a request start from a stale count, so hold at least one cycle.
  localparam int unsigned SettleMax = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam int unsigned SettleW   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               clamp_hi;

  cor_state_e         state_q;
  cor_state_e         state_d;
  logic [SettleW-1:0] settle_q;
  logic [SettleW-1:0] settle_d;
  logic               decr_q;
  logic               decr_d;

  // Counter datapath: the tally block has already merged adds and echoed decrements.
  cmm_errman_sat_add #(
    .CNT_W (CNT_W),
    .DW    (CorNumW)
  ) u_sat_add (
    .cnt_i      (cnt_q),
    .delta_i    (bus.cor_num),
    .add_i      (bus.inc_dec_b == Inc),
    .cnt_o      (cnt_d),
    .clamp_hi_o (clamp_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    decr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((cnt_q != '0) && bus.cor_en) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // Once raised the request is never withdrawn, even if reporting is disabled.
        if (bus.msg_ack) begin
          state_d  = StSettle;
          settle_d = '0;
          decr_d   = 1'b1;
        end
      end
      StSettle: begin
        if (settle_q == SettleW'(SettleMax)) begin
          state_d  = StIdle;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        settle_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      decr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      decr_q   <= decr_d;
    end
  end

  // Request decoded from state so an asynchronous reset drops it immediately.
  assign bus.cor_msg_req = (state_q == StReq);
  assign bus.decr_cor    = decr_q;
  assign bus.cor_cnt     = cnt_q;

`ifdef CMM_ERRMAN_COR_OVFL_EN
  logic ovfl_q;
  logic ovfl_d;
  logic unused_in;

  // Set wins over a simultaneous clear.
  always_comb begin
    ovfl_d = ovfl_q;
    if (bus.ovfl_clr) begin
      ovfl_d = 1'b0;
    end
    if (clamp_hi) begin
      ovfl_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl_q <= 1'b0;
    end else begin
      ovfl_q <= ovfl_d;
    end
  end

  assign bus.cor_ovfl = ovfl_q;
  assign unused_in    = bus.reg_decr_cor;
`else
  logic unused_in;

  assign bus.cor_ovfl = 1'b0;
  assign unused_in    = ^{bus.reg_decr_cor, bus.ovfl_clr, clamp_hi};
`endif

endmodule

// File: tb/tb_cmm_errman_cor_cnt.sv
// Directed bench for cmm_errman_cor_cnt with hand-computed expectations.
// Overflow expectations follow CMM_ERRMAN_COR_OVFL_EN.
module tb_cmm_errman_cor_cnt;
  import cmm_errman_pkg::*;

  localparam int unsigned CntW = 4;

`ifdef CMM_ERRMAN_COR_OVFL_EN
  localparam logic OvflOn = 1'b1;
`else
  localparam logic OvflOn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  cmm_errman_cor_cnt_if #(.CNT_W(CntW)) bus ();

  cmm_errman_cor_cnt #(
    .CNT_W      (CntW),
    .SETTLE_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] num, input logic dir);
    bus.cor_num   = num;
    bus.inc_dec_b = dir;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.cor_num      = '0;
    bus.inc_dec_b    = Inc;
    bus.reg_decr_cor = 1'b0;
    bus.msg_ack      = 1'b0;
    bus.ovfl_clr     = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk            = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.cor_num      = '0;
    bus.inc_dec_b    = Inc;
    bus.reg_decr_cor = 1'b0;
    bus.cor_en       = 1'b1;
    bus.msg_ack      = 1'b0;
    bus.ovfl_clr     = 1'b0;
    #3;
    chk("rst_cnt", 32'(bus.cor_cnt), 0);
    chk("rst_req", 32'(bus.cor_msg_req), 0);
    chk("rst_decr", 32'(bus.decr_cor), 0);
    chk("rst_ovfl", 32'(bus.cor_ovfl), 0);
    step();
    rst_n = 1'b1;

    // Three adds of 3; request follows the cycle after the count reaches 3.
    drive(3, Inc); step();
    chk("inc1_cnt", 32'(bus.cor_cnt), 3);
    chk("inc1_req", 32'(bus.cor_msg_req), 0);
    step();
    chk("inc2_cnt", 32'(bus.cor_cnt), 6);
    chk("inc2_req", 32'(bus.cor_msg_req), 1);
    step();
    chk("inc3_cnt", 32'(bus.cor_cnt), 9);
    drive(0, Inc); step();
    chk("hold_req", 32'(bus.cor_msg_req), 1);
    chk("hold_decr", 32'(bus.decr_cor), 0);
    bus.msg_ack = 1'b1; step();
    chk("ack9_decr", 32'(bus.decr_cor), 1);
    chk("ack9_req", 32'(bus.cor_msg_req), 0);
    bus.msg_ack = 1'b0; drive(1, Dec); step();
    chk("echo9_cnt", 32'(bus.cor_cnt), 8);
    chk("echo9_decr", 32'(bus.decr_cor), 0);
    chk("settle9_req", 32'(bus.cor_msg_req), 0);
    drive(0, Inc); step();
    chk("idle9_req", 32'(bus.cor_msg_req), 0);
    step();
    chk("rereq8_req", 32'(bus.cor_msg_req), 1);

    // Single error: one message, echo drains to zero, no further request.
    do_reset();
    drive(1, Inc); step();
    chk("one_cnt", 32'(bus.cor_cnt), 1);
    drive(0, Inc); step();
    chk("one_req", 32'(bus.cor_msg_req), 1);
    bus.msg_ack = 1'b1; step();
    chk("one_decr", 32'(bus.decr_cor), 1);
    chk("one_req_low", 32'(bus.cor_msg_req), 0);
    bus.msg_ack = 1'b0; drive(1, Dec); step();
    chk("one_echo_cnt", 32'(bus.cor_cnt), 0);
    chk("one_decr_once", 32'(bus.decr_cor), 0);
    drive(0, Inc); step();
    step();
    step();
    chk("one_no_req", 32'(bus.cor_msg_req), 0);
    chk("one_final_cnt", 32'(bus.cor_cnt), 0);

    // Saturation at the top and the sticky overflow flag.
    do_reset();
    bus.cor_en = 1'b0;
    drive(6, Inc); step();
    step();
    drive(2, Inc); step();
    chk("pre_sat_cnt", 32'(bus.cor_cnt), 14);
    chk("pre_sat_ovfl", 32'(bus.cor_ovfl), 0);
    drive(5, Inc); step();
    chk("sat_cnt", 32'(bus.cor_cnt), 15);
    chk("sat_ovfl", 32'(bus.cor_ovfl), 32'(OvflOn));
    drive(0, Inc); step();
    chk("sat_ovfl_sticky", 32'(bus.cor_ovfl), 32'(OvflOn));
    bus.ovfl_clr = 1'b1; step();
    chk("ovfl_cleared", 32'(bus.cor_ovfl), 0);
    drive(1, Inc); step();
    chk("max_hold_cnt", 32'(bus.cor_cnt), 15);
    chk("set_beats_clr", 32'(bus.cor_ovfl), 32'(OvflOn));
    drive(0, Inc); step();
    chk("ovfl_clr2", 32'(bus.cor_ovfl), 0);
    bus.ovfl_clr = 1'b0;

    // Saturation at zero, stray ack and stray echo are ignored.
    do_reset();
    bus.cor_en = 1'b0;
    drive(2, Inc); step();
    drive(6, Dec); step();
    chk("sub_clamp_cnt", 32'(bus.cor_cnt), 0);
    drive(3, Dec); step();
    chk("sub_at0_cnt", 32'(bus.cor_cnt), 0);
    drive(0, Inc); bus.msg_ack = 1'b1; step();
    chk("stray_ack_decr", 32'(bus.decr_cor), 0);
    chk("stray_ack_req", 32'(bus.cor_msg_req), 0);
    bus.msg_ack = 1'b0; drive(5, Inc); step();
    drive(0, Inc); bus.reg_decr_cor = 1'b1; step();
    chk("stray_echo_cnt", 32'(bus.cor_cnt), 5);
    bus.reg_decr_cor = 1'b0;

    // Enable dropped while requesting: request held, then no new request.
    do_reset();
    bus.cor_en = 1'b1;
    drive(5, Inc); step();
    drive(0, Inc); step();
    chk("en_req", 32'(bus.cor_msg_req), 1);
    bus.cor_en = 1'b0; step();
    chk("en_drop_req", 32'(bus.cor_msg_req), 1);
    bus.msg_ack = 1'b1; step();
    chk("en_drop_decr", 32'(bus.decr_cor), 1);
    bus.msg_ack = 1'b0; drive(1, Dec); step();
    chk("en_drop_cnt", 32'(bus.cor_cnt), 4);
    drive(0, Inc); step();
    step();
    step();
    chk("en_off_no_req", 32'(bus.cor_msg_req), 0);
    chk("en_off_cnt", 32'(bus.cor_cnt), 4);

    // Asynchronous reset in the middle of a request.
    do_reset();
    bus.cor_en = 1'b1;
    drive(2, Inc); step();
    drive(0, Inc); step();
    chk("mid_req", 32'(bus.cor_msg_req), 1);
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(bus.cor_msg_req), 0);
    chk("async_cnt", 32'(bus.cor_cnt), 0);
    chk("async_decr", 32'(bus.decr_cor), 0);
    step();
    rst_n       = 1'b1;
    bus.msg_ack = 1'b1;
    step();
    chk("post_rst_decr", 32'(bus.decr_cor), 0);
    chk("post_rst_req", 32'(bus.cor_msg_req), 0);
    bus.msg_ack = 1'b0;
    step();
    chk("post_rst_decr2", 32'(bus.decr_cor), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmm_errman_cor_cnt.md
CMM_ERRMAN_COR_CNT -- requirements
Module: cmm_errman_cor_cnt

Interface
REQ-001 Parameter CNT_W, default 4: width of the outstanding-correctable-error counter.
REQ-002 Parameter SETTLE_CYC, default 2: cycles to block new message requests after each decrement.
REQ-003 Port clk  in  1: single clock; all state on rising edge.
REQ-004 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 Port cor_num  in  3: error-count delta from the correctable-error tally block, range 0..6.
REQ-006 Port inc_dec_b  in  1: 1 = add cor_num, 0 = subtract cor_num.
REQ-007 Port reg_decr_cor  in  1: registered echo of decr_cor from the tally block.
REQ-008 Port cor_en  in  1: correctable-error reporting enable (device control).
REQ-009 Port msg_ack  in  1: message transmitter accepts the ERR_COR request.
REQ-010 Port cor_msg_req  out  1: request to send one ERR_COR message.
REQ-011 Port decr_cor  out  1: one-cycle pulse to the tally block, one message was sent.
REQ-012 Port cor_cnt  out  CNT_W: current outstanding count.
REQ-013 Port cor_ovfl  out  1: sticky saturation flag.
REQ-014 Port ovfl_clr  in  1: clears cor_ovfl.

Function
REQ-015 Counter update every cycle: next = cor_cnt + cor_num if inc_dec_b=1, else cor_cnt - cor_num; result clamped to 0..2^CNT_W-1.
REQ-016 Arithmetic in CNT_W+1 bits before clamping; no wrap-around in either direction.
REQ-017 cor_cnt is a register; its value reflects the delta one cycle after cor_num/inc_dec_b are sampled.
REQ-018 FSM states: IDLE, REQ, SETTLE.
REQ-019 IDLE -> REQ when cor_cnt != 0 and cor_en=1; cor_msg_req is asserted from the next cycle.
REQ-020 In REQ, cor_msg_req stays high until msg_ack=1; it is never withdrawn, including when cor_en drops.
REQ-021 REQ with msg_ack=1 -> SETTLE; decr_cor=1 for exactly the next cycle; cor_msg_req=0 in that same cycle.
REQ-022 SETTLE lasts SETTLE_CYC cycles, then returns to IDLE. New requests cannot start from stale cor_cnt.
REQ-023 msg_ack outside REQ is ignored, with no state or count change.
REQ-024 reg_decr_cor=1 without a prior decr_cor pulse is ignored; cor_cnt changes only via REQ-015.
REQ-025 Subtract at cor_cnt=0 leaves 0; add at maximum leaves maximum.
REQ-026 Simultaneous add delta and decrement echo are already merged upstream into one delta; apply that single delta as-is.

Reset
REQ-027 rst_n=0 asynchronously forces cor_cnt=0, cor_msg_req=0, decr_cor=0, cor_ovfl=0, FSM=IDLE, settle counter=0.
REQ-028 Reset mid-REQ drops cor_msg_req immediately; a msg_ack arriving after reset release is ignored per REQ-023.
REQ-029 Reset release is sampled synchronously (first update on the first clk edge after rst_n rises).

Configuration
REQ-030 Macro CMM_ERRMAN_COR_OVFL_EN defined: cor_ovfl sets when an add is clamped at maximum and stays set until ovfl_clr=1. Set has priority over a simultaneous clear.
REQ-031 Macro undefined: cor_ovfl is tied 0, ovfl_clr is unused, and no overflow logic is built.

Structure
REQ-032 Shared package cmm_errman_pkg holds the FSM state enum, the CNT_W default, and the INC=1/DEC=0 encoding constants.
REQ-033 One sub-module, cmm_errman_sat_add: CNT_W saturating add/subtract with a clamp-high indicator. It is instantiated once.

Verification
REQ-034 Reset, cor_en=1, three cycles of cor_num=3 inc -> cor_cnt=9; cor_msg_req rises the cycle after cor_cnt becomes 3.
REQ-035 cor_cnt=1, msg_ack in REQ -> decr_cor pulses 1 cycle; tally returns cor_num=1 dec -> cor_cnt=0; no new req after SETTLE_CYC.
REQ-036 cor_cnt=14, cor_num=5 inc -> cor_cnt=15; with the macro, cor_ovfl=1; ovfl_clr -> 0; without the macro, cor_ovfl stays 0.
REQ-037 cor_cnt=2, cor_num=6 dec -> cor_cnt=0, no wrap; msg_ack pulse while IDLE -> no decr_cor.
REQ-038 cor_en falls while in REQ -> req held; msg_ack -> normal decr_cor; then no new req while cor_en=0 and cor_cnt=4.
REQ-039 rst_n low for 1 cycle mid-REQ -> all outputs 0 asynchronously; next cycle msg_ack=1 -> ignored.
